// File: rtl/irq_ctrl_pkg.sv
// Shared types and register map for the interrupt controller.
package irq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACTIVE = 2'd2
  } irq_state_t;

  localparam int unsigned REG_W = 32;
  localparam logic [1:0] IRQ_REG_ENABLE  = 2'd0;
  localparam logic [1:0] IRQ_REG_PENDING = 2'd1;
  localparam logic [1:0] IRQ_REG_ACTIVE  = 2'd2;
  localparam int unsigned ACTIVE_VLD_BIT = 31;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder over the enabled pending vector.
module irq_prio_enc #(
  parameter  int unsigned N_SRC = 8,
  localparam int unsigned ID_W  = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  output logic             any,
  output logic [ID_W-1:0]  id
);

  // Scan from the top so the lowest set index is the last assignment.
  always_comb begin
    any = 1'b0;
    id  = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        any = 1'b1;
        id  = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Edge-detecting, maskable interrupt controller with claim/complete handshake.
// Define IRQ_CTRL_SYNC_EN to put a 2-flop synchronizer on every irq_src line.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter  int unsigned N_SRC = 8,
  localparam int unsigned ID_W  = $clog2(N_SRC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_SRC-1:0]   irq_src,
  input  logic [1:0]         reg_addr,
  input  logic               reg_we,
  input  logic [REG_W-1:0]   reg_wdata,
  output logic [REG_W-1:0]   reg_rdata,
  output logic               irq,
  output logic [ID_W-1:0]    irq_id,
  input  logic               irq_claim,
  input  logic               irq_complete,
  input  logic [ID_W-1:0]    irq_complete_id
);

  irq_state_t       state, state_nxt;
  logic [N_SRC-1:0] src_s, src_q, edges;
  logic [N_SRC-1:0] pending, enable, pend_en;
  logic [N_SRC-1:0] w1c_mask, claim_mask;
  logic             win_any;
  logic [ID_W-1:0]  win_id;
  logic             claim_go, done_go, irq_nxt;
  logic             active_vld;
  logic [ID_W-1:0]  active_id;

`ifdef IRQ_CTRL_SYNC_EN
  logic [N_SRC-1:0] sync1, sync2;

  // Free-running synchronizer so lines are already settled when reset releases.
  always_ff @(posedge clk) begin
    sync1 <= irq_src;
    sync2 <= sync1;
  end

  assign src_s = sync2;
`else
  assign src_s = irq_src;
`endif

  if (N_SRC < REG_W) begin : g_unused_wdata
    logic unused_wdata;
    assign unused_wdata = ^reg_wdata[REG_W-1:N_SRC];
  end

  assign edges    = src_s & ~src_q;
  assign pend_en  = pending & enable;
  assign w1c_mask = (reg_we && reg_addr == IRQ_REG_PENDING) ? reg_wdata[N_SRC-1:0] : '0;
  assign claim_mask = claim_go ? (N_SRC'(1) << win_id) : '0;

  irq_prio_enc #(.N_SRC(N_SRC)) u_prio_enc (
    .req (pend_en),
    .any (win_any),
    .id  (win_id)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    claim_go  = 1'b0;
    done_go   = 1'b0;
    case (state)
      IDLE: begin
        if (win_any) state_nxt = REQ;
      end
      REQ: begin
        if (!win_any) begin
          state_nxt = IDLE;
        end else if (irq_claim) begin
          state_nxt = ACTIVE;
          claim_go  = 1'b1;
        end
      end
      ACTIVE: begin
        if (irq_complete && irq_complete_id == active_id) begin
          state_nxt = IDLE;
          done_go   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    irq_nxt = (state_nxt == REQ);
  end

  // irq_id follows the live winner while requesting, holds otherwise.
  always_ff @(posedge clk) begin
    if (!rst) begin
      irq    <= 1'b0;
      irq_id <= '0;
    end else begin
      irq <= irq_nxt;
      if (irq_nxt) irq_id <= win_id;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      active_vld <= 1'b0;
      active_id  <= '0;
    end else if (claim_go) begin
      active_vld <= 1'b1;
      active_id  <= win_id;
    end else if (done_go) begin
      active_vld <= 1'b0;
      active_id  <= '0;
    end
  end

  // src_q follows the input during reset so lines already high are not new edges.
  always_ff @(posedge clk) begin
    if (!rst) begin
      src_q   <= src_s;
      pending <= '0;
      enable  <= '0;
    end else begin
      src_q   <= src_s;
      pending <= (pending & ~w1c_mask & ~claim_mask) | edges;
      if (reg_we && reg_addr == IRQ_REG_ENABLE) enable <= reg_wdata[N_SRC-1:0];
    end
  end

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      IRQ_REG_ENABLE:  reg_rdata = REG_W'(enable);
      IRQ_REG_PENDING: reg_rdata = REG_W'(pending);
      IRQ_REG_ACTIVE: begin
        reg_rdata[ACTIVE_VLD_BIT] = active_vld;
        reg_rdata[ID_W-1:0]       = active_id;
      end
      default: reg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus a randomized run against a reference model.
module tb_irq_ctrl;

`ifdef IRQ_CTRL_SYNC_EN
  localparam int SRC_DLY = 2;
`else
  localparam int SRC_DLY = 0;
`endif
  localparam int LAT = 2 + SRC_DLY;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  irq_src = '0;
  logic [1:0]  reg_addr = '0;
  logic        reg_we = 1'b0;
  logic [31:0] reg_wdata = '0;
  logic [31:0] reg_rdata;
  logic        irq;
  logic [2:0]  irq_id;
  logic        irq_claim = 1'b0;
  logic        irq_complete = 1'b0;
  logic [2:0]  irq_complete_id = '0;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: pending/enable masks, a 0/1/2 phase (idle/offering/in handler)
  logic [7:0] m_pend, m_en, m_srcq, m_s1, m_s2;
  int         m_phase, m_offer, m_act;
  logic       m_vld;

  irq_ctrl #(.N_SRC(8)) dut (
    .clk(clk), .rst(rst), .irq_src(irq_src), .reg_addr(reg_addr), .reg_we(reg_we),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .irq(irq), .irq_id(irq_id),
    .irq_claim(irq_claim), .irq_complete(irq_complete), .irq_complete_id(irq_complete_id)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic void model_step();
    logic [7:0] src_in, edges, np;
    int w;
    src_in = (SRC_DLY != 0) ? m_s2 : irq_src;
    m_s2 = m_s1;
    m_s1 = irq_src;
    if (!rst) begin
      m_srcq = src_in; m_pend = '0; m_en = '0;
      m_phase = 0; m_offer = 0; m_act = 0; m_vld = 1'b0;
      return;
    end
    edges = src_in & ~m_srcq;
    m_srcq = src_in;
    w = lowest(m_pend & m_en);
    np = m_pend;
    if (reg_we && reg_addr == 2'd1) np = np & ~reg_wdata[7:0];
    if (m_phase == 0) begin
      if (w >= 0) begin m_phase = 1; m_offer = w; end
    end else if (m_phase == 1) begin
      if (w < 0) m_phase = 0;
      else if (irq_claim) begin
        np[w] = 1'b0; m_act = w; m_vld = 1'b1; m_phase = 2;
      end else m_offer = w;
    end else begin
      if (irq_complete && int'(irq_complete_id) == m_act) begin
        m_phase = 0; m_vld = 1'b0; m_act = 0;
      end
    end
    m_pend = np | edges;
    if (reg_we && reg_addr == 2'd0) m_en = reg_wdata[7:0];
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0: return {24'd0, m_en};
      2'd1: return {24'd0, m_pend};
      2'd2: return {m_vld, 28'd0, 3'(m_act)};
      default: return 32'd0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic settle();
    for (int i = 0; i < SRC_DLY; i++) tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    reg_addr = a; reg_wdata = d; reg_we = 1'b1;
    tick();
    reg_we = 1'b0; reg_wdata = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    reg_addr = a;
    #1;
    d = reg_rdata;
  endtask

  task automatic pulse_claim();
    irq_claim = 1'b1; tick(); irq_claim = 1'b0;
  endtask

  task automatic pulse_complete(input logic [2:0] id);
    irq_complete = 1'b1; irq_complete_id = id; tick(); irq_complete = 1'b0; irq_complete_id = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    irq_src = '0;
    do_reset();
    if (irq !== 1'b0) begin $display("FAIL reset_irq: got %0b expected 0", irq); n_fail++; end
    n_chk++;
    if (irq_id !== 3'd0) begin $display("FAIL reset_irq_id: got %0d expected 0", irq_id); n_fail++; end
    n_chk++;
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      if (d !== 32'd0) begin $display("FAIL reset_reg%0d: got %h expected 0", a, d); n_fail++; end
      n_chk++;
    end
  endtask

  task automatic test_latency();
    logic [31:0] d;
    int lat, held;
    do_reset();
    wr(2'd0, 32'h04);
    irq_src = 8'h04;
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (irq === 1'b1) begin lat = c; break; end
    end
    if (lat != LAT) begin $display("FAIL latency: got %0d cycles expected %0d", lat, LAT); n_fail++; end
    n_chk++;
    if (irq_id !== 3'd2) begin $display("FAIL latency_id: got %0d expected 2", irq_id); n_fail++; end
    n_chk++;
    held = (lat == 0) ? 10 : lat;
    for (int c = held; c < 16; c++) tick();
    rd(2'd1, d);
    if (d !== 32'h04) begin $display("FAIL latency_pending: got %h expected 04", d); n_fail++; end
    n_chk++;
    irq_src = '0;
  endtask

  task automatic test_priority();
    logic [31:0] d;
    do_reset();
    wr(2'd0, 32'hFF);
    irq_src = 8'h22;
    tick(); settle(); tick();
    if (irq !== 1'b1 || irq_id !== 3'd1) begin $display("FAIL prio_offer: got irq=%0b id=%0d expected irq=1 id=1", irq, irq_id); n_fail++; end
    n_chk++;
    pulse_claim();
    rd(2'd1, d);
    if (d !== 32'h20) begin $display("FAIL prio_pending_after_claim: got %h expected 20", d); n_fail++; end
    n_chk++;
    rd(2'd2, d);
    if (d !== 32'h80000001) begin $display("FAIL prio_active_id: got %h expected 80000001", d); n_fail++; end
    n_chk++;
    if (irq !== 1'b0) begin $display("FAIL prio_irq_after_claim: got %0b expected 0", irq); n_fail++; end
    n_chk++;
    pulse_complete(3'd1);
    if (irq !== 1'b0) begin $display("FAIL prio_irq_at_complete: got %0b expected 0", irq); n_fail++; end
    n_chk++;
    tick();
    if (irq !== 1'b1 || irq_id !== 3'd5) begin $display("FAIL prio_next_offer: got irq=%0b id=%0d expected irq=1 id=5", irq, irq_id); n_fail++; end
    n_chk++;
    irq_src = '0;
  endtask

  task automatic test_enable_gate();
    logic [31:0] d;
    do_reset();
    wr(2'd0, 32'h00);
    irq_src = 8'h08;
    tick(); settle();
    rd(2'd1, d);
    if (d !== 32'h08) begin $display("FAIL gate_pending: got %h expected 08", d); n_fail++; end
    n_chk++;
    tick();
    if (irq !== 1'b0) begin $display("FAIL gate_masked_irq: got %0b expected 0", irq); n_fail++; end
    n_chk++;
    wr(2'd0, 32'h08);
    tick();
    if (irq !== 1'b1 || irq_id !== 3'd3) begin $display("FAIL gate_enable_irq: got irq=%0b id=%0d expected irq=1 id=3", irq, irq_id); n_fail++; end
    n_chk++;
    wr(2'd1, 32'h08);
    tick();
    if (irq !== 1'b0) begin $display("FAIL gate_w1c_drop: got %0b expected 0", irq); n_fail++; end
    n_chk++;
    irq_src = '0;
  endtask

  task automatic test_complete_mismatch();
    logic [31:0] d;
    do_reset();
    wr(2'd0, 32'hFF);
    irq_src = 8'h10;
    tick(); settle(); tick();
    pulse_claim();
    pulse_complete(3'd2);
    rd(2'd2, d);
    if (d !== 32'h80000004) begin $display("FAIL mismatch_ignored: got %h expected 80000004", d); n_fail++; end
    n_chk++;
    pulse_complete(3'd4);
    rd(2'd2, d);
    if (d !== 32'h0) begin $display("FAIL match_completes: got %h expected 0", d); n_fail++; end
    n_chk++;
    irq_src = '0;
  endtask

  task automatic test_races();
    logic [31:0] d;
    do_reset();
    irq_src = 8'h40;
    settle();
    wr(2'd1, 32'h40);
    rd(2'd1, d);
    if (d !== 32'h40) begin $display("FAIL w1c_vs_set: got %h expected 40", d); n_fail++; end
    n_chk++;
    pulse_claim();
    rd(2'd2, d);
    if (d !== 32'h0 || irq !== 1'b0) begin $display("FAIL idle_claim: got active=%h irq=%0b expected 0 0", d, irq); n_fail++; end
    n_chk++;
    // Edge on the claimed source in the claim cycle keeps it pending
    do_reset();
    wr(2'd0, 32'hFF);
    irq_src = 8'h02;
    settle(); tick();
    irq_src = 8'h00;
    settle(); tick();
    irq_src = 8'h02;
    settle();
    pulse_claim();
    rd(2'd1, d);
    if (d !== 32'h02) begin $display("FAIL claim_vs_set: got %h expected 02", d); n_fail++; end
    n_chk++;
    irq_src = '0;
  endtask

  task automatic test_reset_mid_handler();
    logic [31:0] d;
    do_reset();
    wr(2'd0, 32'hFF);
    irq_src = 8'h01;
    settle(); tick(); tick();
    pulse_claim();
    irq_src = 8'h00;
    settle(); tick();
    irq_src = 8'h11;
    settle(); tick();
    rd(2'd1, d);
    if (d !== 32'h11) begin $display("FAIL midreset_setup: got %h expected 11", d); n_fail++; end
    n_chk++;
    rst = 1'b0; tick();
    for (int a = 0; a < 3; a++) begin
      rd(2'(a), d);
      if (d !== 32'd0) begin $display("FAIL midreset_reg%0d: got %h expected 0", a, d); n_fail++; end
      n_chk++;
    end
    if (irq !== 1'b0) begin $display("FAIL midreset_irq: got %0b expected 0", irq); n_fail++; end
    n_chk++;
    tick(); tick();
    rst = 1'b1;
    repeat (4) tick();
    rd(2'd1, d);
    if (d !== 32'h0) begin $display("FAIL held_no_retrigger: got %h expected 0", d); n_fail++; end
    n_chk++;
    irq_src = 8'h00;
    settle(); tick();
    irq_src = 8'h01;
    settle(); tick();
    rd(2'd1, d);
    if (d !== 32'h01) begin $display("FAIL retrigger_after_fall: got %h expected 01", d); n_fail++; end
    n_chk++;
    irq_src = '0;
  endtask

  task automatic test_random();
    logic [31:0] d, e;
    do_reset();
    for (int c = 0; c < 500; c++) begin
      rst = ($urandom_range(0, 149) != 0);
      irq_src = irq_src ^ 8'($urandom & $urandom & $urandom);
      reg_we = ($urandom_range(0, 5) == 0);
      reg_wdata = $urandom;
      irq_claim = ($urandom_range(0, 2) == 0);
      irq_complete = ($urandom_range(0, 3) == 0);
      irq_complete_id = $urandom_range(0, 1) ? 3'(m_act) : 3'($urandom_range(0, 7));
      rd(2'($urandom_range(0, 3)), d);
      e = model_read(reg_addr);
      if (d !== e) begin $display("FAIL rand_read[%0d] addr %0d: got %h expected %h", c, reg_addr, d, e); n_fail++; end
      n_chk++;
      if (irq !== (m_phase == 1)) begin $display("FAIL rand_irq[%0d]: got %0b expected %0b", c, irq, m_phase == 1); n_fail++; end
      n_chk++;
      if (m_phase == 1) begin
        if (irq_id !== 3'(m_offer)) begin $display("FAIL rand_irq_id[%0d]: got %0d expected %0d", c, irq_id, m_offer); n_fail++; end
        n_chk++;
      end
      tick();
    end
    rst = 1'b1; reg_we = 1'b0; irq_claim = 1'b0; irq_complete = 1'b0; irq_src = '0;
  endtask

  initial begin
    m_s1 = '0; m_s2 = '0; m_srcq = '0; m_pend = '0; m_en = '0;
    m_phase = 0; m_offer = 0; m_act = 0; m_vld = 1'b0;
    @(negedge clk);
    test_reset();
    test_latency();
    test_priority();
    test_enable_gate();
    test_complete_mismatch();
    test_races();
    test_reset_mid_handler();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
